// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared width helpers, lane config type and counter limit for seq_detector_multi
package seq_det_pkg;
    localparam int PAT_W_MAX = 16;
    localparam int LEN_W_MAX = 5;
    localparam logic [63:0] CNT_SAT = '1;
    typedef struct packed {
        logic [PAT_W_MAX-1:0] pat;
        logic [LEN_W_MAX-1:0] len;
    } lane_cfg_t;
    function automatic int calc_lw(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction
    function automatic int calc_iw(input int n_pat);
        return n_pat > 1 ? $clog2(n_pat) : 1;
    endfunction
endpackage

// File: rtl/seq_det_lane.sv
// seq_det_lane: one pattern lane with fill tracking, compare, match flop and saturating hit counter
module seq_det_lane import seq_det_pkg::*; #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8,
    parameter int LW    = calc_lw(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic             i_bit,
    input  logic [PAT_W-1:0] i_hist,
    input  logic             i_overlap,
    input  logic             i_cfg_we,
    input  logic [PAT_W-1:0] i_cfg_pat,
    input  logic [LW-1:0]    i_cfg_len,
    input  logic             i_cnt_clr,
    output logic             o_match,
    output logic [CNT_W-1:0] o_cnt
);
    lane_cfg_t r_cfg;
    logic [LW-1:0] r_fill;
    logic r_match;
    logic [CNT_W-1:0] r_cnt;
    logic [PAT_W_MAX:0] w_win, w_mask;
    logic w_hit;
    always_comb begin
        w_win  = (PAT_W_MAX+1)'({i_hist, i_bit});
        w_mask = ~({(PAT_W_MAX+1){1'b1}} << r_cfg.len);
        w_hit  = i_valid && !i_cfg_we && r_cfg.len != '0
              && (LEN_W_MAX+1)'(r_fill) + (LEN_W_MAX+1)'(1) >= {1'b0, r_cfg.len}
              && ((w_win ^ {1'b0, r_cfg.pat}) & w_mask) == '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg   <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_match <= w_hit;
            if (i_cfg_we) begin
                r_cfg.pat <= PAT_W_MAX'(i_cfg_pat);
                r_cfg.len <= LEN_W_MAX'(i_cfg_len);
                r_fill    <= '0;
            end else if (i_valid) begin
                r_fill <= (w_hit && !i_overlap) ? '0 : (r_fill == LW'(PAT_W)) ? r_fill : r_fill + LW'(1);
            end
            // clear wins over a coincident hit
            if (i_cnt_clr)
                r_cnt <= '0;
            else if (w_hit && r_cnt != CNT_SAT[CNT_W-1:0])
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end
    assign o_match = r_match;
    assign o_cnt   = r_cnt;
endmodule

// File: rtl/seq_detector_multi.sv
// seq_detector_multi: multi-pattern serial sequence detector with shared history and per-lane counters
module seq_detector_multi import seq_det_pkg::*; #(
    parameter  int N_PAT = 2,
    parameter  int PAT_W = 8,
    parameter  int CNT_W = 8,
    localparam int LW    = calc_lw(PAT_W),
    localparam int IW    = calc_iw(N_PAT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_bit,
    input  logic                   overlap,
    input  logic                   cfg_we,
    input  logic [IW-1:0]          cfg_idx,
    input  logic [PAT_W-1:0]       cfg_pat,
    input  logic [LW-1:0]          cfg_len,
    input  logic                   cnt_clr,
    output logic [N_PAT-1:0]       match,
    output logic                   match_any,
    output logic [N_PAT*CNT_W-1:0] match_cnt
);
    logic [PAT_W-1:0] r_hist;
    logic [LW-1:0] w_len;
    always_ff @(posedge clk) begin
        if (rst)
            r_hist <= '0;
        else if (in_valid)
            r_hist <= {r_hist[PAT_W-2:0], in_bit};
    end
    assign w_len = (cfg_len > LW'(PAT_W)) ? LW'(PAT_W) : cfg_len;
    for (genvar i = 0; i < N_PAT; i++) begin : g_lane
        seq_det_lane #(.PAT_W(PAT_W), .CNT_W(CNT_W), .LW(LW)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .i_valid   (in_valid),
            .i_bit     (in_bit),
            .i_hist    (r_hist),
            .i_overlap (overlap),
            .i_cfg_we  (cfg_we && cfg_idx == IW'(i)),
            .i_cfg_pat (cfg_pat),
            .i_cfg_len (w_len),
            .i_cnt_clr (cnt_clr),
            .o_match   (match[i]),
            .o_cnt     (match_cnt[i*CNT_W +: CNT_W])
        );
    end
    assign match_any = |match;
endmodule

// File: tb/tb_seq_detector_multi.sv
// tb_seq_detector_multi: directed self-checking bench for seq_detector_multi
module tb_seq_detector_multi;
    localparam int N_PAT = 2;
    localparam int PAT_W = 8;
    localparam int CNT_W = 2;
    localparam int LW    = 4;
    localparam int IW    = 1;
    logic clk = 1'b0;
    logic rst, in_valid, in_bit, overlap, cfg_we, cnt_clr;
    logic [IW-1:0] cfg_idx;
    logic [PAT_W-1:0] cfg_pat;
    logic [LW-1:0] cfg_len;
    logic [N_PAT-1:0] match;
    logic match_any;
    logic [N_PAT*CNT_W-1:0] match_cnt;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    seq_detector_multi #(.N_PAT(N_PAT), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .overlap   (overlap),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_pat   (cfg_pat),
        .cfg_len   (cfg_len),
        .cnt_clr   (cnt_clr),
        .match     (match),
        .match_any (match_any),
        .match_cnt (match_cnt)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
    endtask
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            check("stall", 32'(match), 32'd0);
        end
    endtask
    task automatic cfg(input int idx, input logic [PAT_W-1:0] p, input logic [LW-1:0] l);
        cfg_we  = 1'b1;
        cfg_idx = IW'(idx);
        cfg_pat = p;
        cfg_len = l;
        tick();
        cfg_we  = 1'b0;
    endtask
    task automatic clr();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask
    // bits sent MSB first; exp holds the 2-bit match expected after each bit, MSB first
    task automatic run(input string tag, input int n, input logic [15:0] bits, input logic [31:0] exp);
        logic [1:0] e;
        for (int k = 0; k < n; k++) begin
            send(bits[n-1-k]);
            e = exp[2*(n-1-k) +: 2];
            check(tag, 32'(match), 32'(e));
            check({tag, "_any"}, 32'(match_any), 32'(|e));
        end
    endtask
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; overlap = 1'b1;
        cfg_we = 1'b0; cfg_idx = '0; cfg_pat = '0; cfg_len = '0; cnt_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_match", 32'(match), 32'd0);
        check("rst_any", 32'(match_any), 32'd0);
        check("rst_cnt", 32'(match_cnt), 32'd0);
        run("disabled", 16, 16'hB36D, 32'd0);
        check("disabled_cnt", 32'(match_cnt), 32'd0);
        overlap = 1'b1;
        cfg(0, 8'h0B, 4'd4);
        run("ovl", 7, 16'b1011011, 32'h41);
        check("ovl_cnt", 32'(match_cnt), 32'h2);
        clr();
        check("clr_cnt", 32'(match_cnt), 32'd0);
        overlap = 1'b0;
        cfg(0, 8'h0B, 4'd4);
        run("novl", 7, 16'b1011011, 32'h40);
        check("novl_cnt", 32'(match_cnt), 32'h1);
        clr();
        overlap = 1'b1;
        cfg(0, 8'h05, 4'd3);
        cfg(1, 8'h01, 4'd2);
        send(1'b1);
        check("stall_b1", 32'(match), 32'd0);
        idle(3);
        send(1'b0);
        check("stall_b2", 32'(match), 32'd0);
        idle(3);
        send(1'b1);
        check("stall_b3", 32'(match), 32'h3);
        check("stall_any", 32'(match_any), 32'd1);
        idle(1);
        check("stall_cnt", 32'(match_cnt), 32'h5);
        run("pre_cfg", 2, 16'b10, 32'h0);
        cfg_we = 1'b1; cfg_idx = '0; cfg_pat = 8'h05; cfg_len = 4'd3;
        send(1'b1);
        cfg_we = 1'b0;
        check("cfg_valid", 32'(match), 32'h2);
        run("post_cfg", 3, 16'b101, 32'h03);
        send(1'b0);
        check("fill_pre", 32'(match), 32'd0);
        cfg(0, 8'h05, 4'd3);
        send(1'b1);
        check("fill_rst", 32'(match), 32'h2);
        cfg(0, 8'h00, 4'd0);
        cfg(1, 8'hA5, 4'hF);
        run("clamp", 8, 16'hA5, 32'h0002);
        cfg(1, 8'h00, 4'd0);
        clr();
        cfg(0, 8'h01, 4'd1);
        run("len1", 5, 16'b11111, 32'h155);
        check("sat_cnt", 32'(match_cnt), 32'h3);
        cnt_clr = 1'b1;
        send(1'b1);
        cnt_clr = 1'b0;
        check("clr_hit_match", 32'(match), 32'h1);
        check("clr_hit_cnt", 32'(match_cnt), 32'd0);
        cfg(0, 8'h05, 4'd3);
        run("pre_rst", 2, 16'b10, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_match", 32'(match), 32'd0);
        check("mid_rst_cnt", 32'(match_cnt), 32'd0);
        run("post_rst", 3, 16'b101, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
